reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Parametrised successor to the single-output power-on reset. Holds STAGES reset outputs asserted after power-up, a hard reset or a soft request, then releases them in order, one every DELAY enabled cycles. Assertion is asynchronous and release is synchronous to clk. Sits at the top level and drives reset to each subsystem in dependency order: clocking, bus, peripherals, application.

Parameters:
STAGES, 4, number of reset outputs, released in index order 0..STAGES-1; minimum 1
DELAY, 4, enabled clk cycles between releases, and before the first release; minimum 1
SYNC_STAGES, 2, depth of the reset-deassertion synchroniser; minimum 2
ACK_TIMEOUT, 16, cycles to wait for a stage acknowledge (used only with RESET_SEQ_ACK_EN); minimum 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; counting pauses while low
soft_req  input  1  synchronous soft-reset request, one-cycle pulse or level
ack  input  STAGES  per-stage ready acknowledge, synchronous to clk; ignored without RESET_SEQ_ACK_EN
rst  output  STAGES  active-high reset outputs, one per subsystem
stage  output  $clog2(STAGES+1)  number of stages released so far (0..STAGES)
done  output  1  high when all stages are released
fault  output  1  sticky acknowledge-timeout flag; tied 0 without RESET_SEQ_ACK_EN

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high. While reset is high, every flop is cleared immediately with no clk edge: rst=all ones, stage=0, done=0, fault=0, delay counter=0, state=HOLD, synchroniser chain=all ones.
- States: HOLD, COUNT, ACK (only with RESET_SEQ_ACK_EN), DONE.
- HOLD: the synchroniser chain shifts in 0 on each edge. On the edge where the chain output becomes 0, the block enters COUNT. HOLD lasts SYNC_STAGES edges after reset falls. en has no effect in HOLD.
- COUNT: the counter increments on each edge with en=1 and holds its value when en=0. On the edge with count==DELAY-1 and en=1:
  - rst[stage] clears
  - stage increments
  - counter returns to 0
  - if that was the last stage, go to DONE and set done=1 on the same edge
- Timing: number edges from the first edge after reset falls as edge 1. With en held high, rst[i] is low after edge SYNC_STAGES+(i+1)*DELAY.
- DONE: all outputs are stable; rst=0, done=1, stage=STAGES.
- soft_req sampled high in any state:
  - next edge: rst=all ones, stage=0, done=0, counter=0, chain reloaded to all ones, state=HOLD
  - soft_req wins over a release scheduled for the same edge
  - a level-held soft_req keeps the block in HOLD
  - fault is not cleared
- Release is monotonic: rst bits never re-assert except through reset, soft_req or fault.
- Widths: counter width max(1,$clog2(DELAY)). DELAY=1 releases one stage per enabled cycle.

Optional Feature:
Macro: RESET_SEQ_ACK_EN
- Defined: after rst[i] clears, the block enters ACK instead of counting the next delay.
  - In ACK, a timeout counter runs every cycle, regardless of en.
  - ack[i]=1 leaves ACK the next edge: to COUNT, or to DONE if i was the last stage. done rises only after the last stage's ack.
  - If ACK_TIMEOUT cycles pass without ack[i]: fault=1 (sticky until reset), rst=all ones, state=HOLD, sequence restarts.
- Not defined: no ACK state, ack is ignored, fault is constant 0, timing as above.

Decomposition:
- Package reset_seq_pkg: state enum typedef (HOLD, COUNT, ACK, DONE) and width helper functions for counter, stage and timeout widths.
- One sub-module, rst_sync_chain: SYNC_STAGES-deep synchroniser, asynchronous set on reset, shifts 0 on clk. Instantiated once.

Test Plan:
1. STAGES=3, DELAY=4, SYNC=2, en=1; hold reset 5 cycles then release -> rst=111 during reset; rst[0] low after edge 6, rst[1] after edge 10, rst[2] and done=1 after edge 14; stage reads 1, 2, 3.
2. Same config, en=0 for 3 cycles starting at edge 8 -> rst[1] low after edge 13, rst[2] and done after edge 17.
3. soft_req pulse at edge 11 -> rst=111 after edge 12 with stage=0 and done=0; rst[0] low after edge 18.
4. In DONE, raise reset mid-clock-period -> rst=111, done=0, stage=0 before the next clk edge; clean restart after reset falls.
5. STAGES=1, DELAY=1 -> rst low and done=1 after edge 3.
6. RESET_SEQ_ACK_EN defined, ACK_TIMEOUT=16, ack held 0 -> fault=1 and rst=111 16 cycles after rst[0] falls, then the sequence repeats. With ack[i] driven 2 cycles after each release -> done=1 and fault=0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type and width helpers for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Delay counter width; a DELAY of 1 still needs a one-bit counter.
    function automatic int cnt_w(input int delay);
        return (delay > 1) ? $clog2(delay) : 1;
    endfunction

    // Width of the released-stage count, which spans 0..STAGES inclusive.
    function automatic int stage_w(input int stages);
        return (stages > 0) ? $clog2(stages + 1) : 1;
    endfunction

    // Acknowledge timeout counter only needs to reach ACK_TIMEOUT-1.
    function automatic int tmo_w(input int timeout);
        return cnt_w(timeout);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rtl/rst_sync_chain.sv - reset-deassertion synchroniser, set asynchronously, drains zeros on clk
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic sync_out,
    output logic sync_next
);

    logic [SYNC_STAGES-1:0] chain;

    // Set immediately on reset, reload on request, otherwise shift a zero toward the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else if (load) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // sync_next is the value the output takes on the coming edge, so the sequencer
    // can leave HOLD on the same edge the chain output drops.
    assign sync_out  = chain[SYNC_STAGES-1];
    assign sync_next = chain[SYNC_STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release, one output every DELAY enabled cycles; RESET_SEQ_ACK_EN adds per-stage acknowledge
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES      = 4,
    parameter int DELAY       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         soft_req,
    input  logic [STAGES-1:0]            ack,
    output logic [STAGES-1:0]            rst,
    output logic [stage_w(STAGES)-1:0]   stage,
    output logic                         done,
    output logic                         fault
);

    localparam int CW = cnt_w(DELAY);
    localparam int SW = stage_w(STAGES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DELAY - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);

    seq_state_e        state;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     stage_q;
    logic [STAGES-1:0] rst_q;
    logic              done_q;
    logic              fault_q;
    logic [STAGES-1:0] rel_mask;
    logic              chain_load;
    logic              sync_out;
    logic              sync_next;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .load      (chain_load),
        .sync_out  (sync_out),
        .sync_next (sync_next)
    );

    // One-hot select of the next stage to release, avoiding an oversized index.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            rel_mask[i] = (stage_q == SW'(i));
        end
    end

`ifdef RESET_SEQ_ACK_EN
    localparam int TW = tmo_w(ACK_TIMEOUT);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0]     STAGE_ALL = SW'(STAGES);

    logic [TW-1:0]     tmo;
    logic [STAGES-1:0] ack_mask;
    logic              ack_hit;
    logic              ack_expired;

    // The stage awaiting acknowledge is the one just released, i.e. stage_q-1.
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            ack_mask[i] = (stage_q == SW'(i + 1));
        end
    end

    assign ack_hit     = |(ack & ack_mask);
    assign ack_expired = (state == ACK) && !ack_hit && (tmo == TMO_LAST);
    assign chain_load  = soft_req | ack_expired;
`else
    logic unused_ack;

    assign unused_ack = (^ack) ^ (ACK_TIMEOUT > 0);
    assign chain_load = soft_req;
`endif

    // Sequencer FSM: hold until the synchroniser drains, then release stages in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= HOLD;
            cnt     <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
            tmo     <= '0;
`endif
        end else if (soft_req) begin
            state   <= HOLD;
            cnt     <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
            tmo     <= '0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (!sync_next || !sync_out) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (en) begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            rst_q   <= rst_q & ~rel_mask;
                            stage_q <= stage_q + 1'b1;
`ifdef RESET_SEQ_ACK_EN
                            state   <= ACK;
                            tmo     <= '0;
`else
                            if (stage_q == STAGE_LAST) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef RESET_SEQ_ACK_EN
                ACK: begin
                    if (ack_hit) begin
                        tmo <= '0;
                        if (stage_q == STAGE_ALL) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end else if (tmo == TMO_LAST) begin
                        fault_q <= 1'b1;
                        rst_q   <= '1;
                        stage_q <= '0;
                        cnt     <= '0;
                        tmo     <= '0;
                        state   <= HOLD;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
`endif
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    assign rst   = rst_q;
    assign stage = stage_q;
    assign done  = done_q;
    assign fault = fault_q;

endmodule
